// File: rtl/mult_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_sequencer
//  Purpose  : Iterative signed multiply / divide engine for the multicycle
//             MIPS core. Executes MULT (shift-add) and DIV (restoring) on
//             operand magnitudes, applies signs in a final step, and holds
//             the architectural HI/LO registers.
//  Ports    : clk      - system clock, rising edge
//             reset    - synchronous, active-high reset
//             start    - one-cycle request pulse from control_unit
//             op       - 0 = MULT, 1 = DIV
//             a        - rs operand (multiplicand / dividend), signed
//             b        - rt operand (multiplier / divisor), signed
//             busy     - high while an operation is in progress
//             done     - registered one-cycle completion pulse
//             div_zero - registered one-cycle pulse, DIV with b == 0
//             hi       - HI register (product high half / remainder)
//             lo       - LO register (product low half / quotient)
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_SIGN = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic               r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    // Multiplicand magnitude for MULT, divisor magnitude for DIV.
    logic [WIDTH-1:0]   r_opnd;
    // MULT: {partial product, remaining multiplier bits}.
    // DIV : low half shifts dividend bits out and quotient bits in.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Magnitudes are taken as unsigned, so the most negative value maps to
    // 2^(WIDTH-1) without overflow.
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_quo_neg;
    logic [WIDTH-1:0]   w_rem_neg;

    assign w_a_mag     = a[WIDTH-1] ? -a : a;
    assign w_b_mag     = b[WIDTH-1] ? -b : b;
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    // The partial remainder is always below the divisor magnitude, so the
    // shifted value and its difference fit in WIDTH+1 bits; bit WIDTH of
    // the difference is the borrow that decides restore vs. keep.
    assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_prod_neg  = -r_acc;
    assign w_quo       = r_acc[WIDTH-1:0];
    assign w_quo_neg   = -w_quo;
    assign w_rem_neg   = -r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_op       <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (op && (b == '0)) begin
                            // Divide by zero: flag immediately, HI/LO untouched.
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_op     <= op;
                            r_sign_a <= a[WIDTH-1];
                            r_sign_b <= b[WIDTH-1];
                            r_count  <= '0;
                            r_rem    <= '0;
                            if (op) begin
                                r_opnd <= w_b_mag;
                                r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                            end else begin
                                r_opnd <= w_a_mag;
                                r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                            end
                            r_state <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    if (r_op) begin
                        if (!w_div_diff[WIDTH]) begin
                            r_rem               <= w_div_diff[WIDTH-1:0];
                            r_acc[WIDTH-1:0]    <= {r_acc[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem               <= w_div_shift[WIDTH-1:0];
                            r_acc[WIDTH-1:0]    <= {r_acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        // Add the multiplicand into the upper half when the
                        // current multiplier bit is set, then shift right.
                        if (r_acc[0]) begin
                            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                        end else begin
                            r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
                        end
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_state <= c_SIGN;
                    end
                end
                c_SIGN: begin
                    if (r_op) begin
                        r_lo <= (r_sign_a ^ r_sign_b) ? w_quo_neg : w_quo;
                        // Remainder carries the dividend's sign.
                        r_hi <= r_sign_a ? w_rem_neg : r_rem;
                    end else if (r_sign_a ^ r_sign_b) begin
                        {r_hi, r_lo} <= w_prod_neg;
                    end else begin
                        {r_hi, r_lo} <= r_acc;
                    end
                    r_done  <= 1'b1;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state != c_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_sequencer
//  Purpose  : Directed self-checking bench for mult_div_sequencer with
//             hand-computed expected HI/LO values, latency and flag checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_sequencer;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_vec  = 0;
    int n_miss = 0;

    mult_div_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Request a one-cycle start; returns #1 after the accepting edge with
    // operands scrambled so that late sampling would be visible.
    task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_0000;
    endtask

    // Count edges until done is seen; also report whether busy dropped early.
    task automatic wait_done(output int cycles, output logic busy_gap);
        cycles   = -1;
        busy_gap = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = i;
                break;
            end
            if (!busy) busy_gap = 1'b1;
        end
    endtask

    int   n;
    logic gap;
    logic seen;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_busy", {31'b0, busy}, 32'd0);
        check_value("reset_done", {31'b0, done}, 32'd0);
        check_value("reset_hi", hi, 32'h0);
        check_value("reset_lo", lo, 32'h0);
        reset = 1'b0;

        // MULT 7 x -3 with full latency/busy profile.
        launch(1'b0, 32'd7, 32'hFFFF_FFFD);
        check_value("m1_busy_k", {31'b0, busy}, 32'd1);
        check_value("m1_done_k", {31'b0, done}, 32'd0);
        wait_done(n, gap);
        check_value("m1_latency", n, 32'd33);
        check_value("m1_busy_gap", {31'b0, gap}, 32'd0);
        check_value("m1_busy_at_done", {31'b0, busy}, 32'd0);
        check_value("m1_hi", hi, 32'hFFFF_FFFF);
        check_value("m1_lo", lo, 32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        check_value("m1_done_pulse", {31'b0, done}, 32'd0);

        launch(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(n, gap);
        check_value("m2_latency", n, 32'd33);
        check_value("m2_hi", hi, 32'h4000_0000);
        check_value("m2_lo", lo, 32'h0000_0000);

        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, gap);
        check_value("m3_hi", hi, 32'h0);
        check_value("m3_lo", lo, 32'h1);

        launch(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(n, gap);
        check_value("d1_latency", n, 32'd33);
        check_value("d1_div_zero", {31'b0, div_zero}, 32'd0);
        check_value("d1_lo", lo, 32'hFFFF_FFFD);
        check_value("d1_hi", hi, 32'h1);

        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, gap);
        check_value("d2_lo", lo, 32'hFFFF_FFFD);
        check_value("d2_hi", hi, 32'hFFFF_FFFF);

        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, gap);
        check_value("d3_lo", lo, 32'h8000_0000);
        check_value("d3_hi", hi, 32'h0);

        // Preload HI/LO, then divide by zero.
        launch(1'b0, 32'h0001_2345, 32'h10);
        wait_done(n, gap);
        check_value("pre_lo", lo, 32'h0012_3450);
        check_value("pre_hi", hi, 32'h0);
        launch(1'b1, 32'd5, 32'd0);
        check_value("dz_done", {31'b0, done}, 32'd1);
        check_value("dz_flag", {31'b0, div_zero}, 32'd1);
        check_value("dz_busy", {31'b0, busy}, 32'd0);
        check_value("dz_lo", lo, 32'h0012_3450);
        check_value("dz_hi", hi, 32'h0);
        @(posedge clk);
        #1;
        check_value("dz_pulse", {31'b0, div_zero}, 32'd0);
        check_value("dz_busy_after", {31'b0, busy}, 32'd0);

        launch(1'b0, 32'd2, 32'd3);
        wait_done(n, gap);
        check_value("m4_div_zero", {31'b0, div_zero}, 32'd0);
        check_value("m4_lo", lo, 32'd6);

        // Start while busy is ignored.
        launch(1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        launch(1'b1, 32'd100, 32'd7);
        wait_done(n, gap);
        check_value("ign_latency", n, 32'd23);
        check_value("ign_lo", lo, 32'd12);
        check_value("ign_hi", hi, 32'd0);

        // Start in the done cycle is accepted.
        launch(1'b1, 32'd100, 32'd7);
        check_value("bb_busy", {31'b0, busy}, 32'd1);
        wait_done(n, gap);
        check_value("bb_latency", n, 32'd33);
        check_value("bb_lo", lo, 32'd14);
        check_value("bb_hi", hi, 32'd2);

        // Reset mid-operation.
        launch(1'b0, 32'd5, 32'd5);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_value("rst_busy", {31'b0, busy}, 32'd0);
        check_value("rst_hi", hi, 32'h0);
        check_value("rst_lo", lo, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check_value("rst_no_done", {31'b0, seen}, 32'd0);

        launch(1'b0, 32'd5, 32'd5);
        wait_done(n, gap);
        check_value("m5_latency", n, 32'd33);
        check_value("m5_lo", lo, 32'd25);
        check_value("m5_hi", hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
